// File: rtl/regbank_arb_if.sv
// Host-side register access bundle shared by the SPI (A) and I2C (B) front-ends.
// Request side: req/wr/addr/wdata, held by the host until ack.
// Response side: ack (one-cycle pulse) with rdata/err valid alongside it.
//
// Signals:
//   req    host -> bank  access request, held until ack
//   wr     host -> bank  1 = write, 0 = read
//   addr   host -> bank  register address
//   wdata  host -> bank  write data
//   ack    bank -> host  one-cycle completion pulse
//   rdata  bank -> host  read data, valid while ack=1
//   err    bank -> host  access error, valid while ack=1
interface regbank_arb_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 8
);
  logic                  req;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0]  wdata;
  logic                  ack;
  logic [REG_WIDTH-1:0]  rdata;
  logic                  err;

  // Host side drives the request, bank side drives the response.
  modport master (output req, wr, addr, wdata, input ack, rdata, err);
  modport slave  (input req, wr, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/regbank_arb.sv
// Config/status register bank shared by two hosts through a round-robin arbiter.
// Latency: grant at edge N, ack/rdata/err registered for exactly the following cycle.
// Backpressure: hosts hold req until ack; a req still high in its ack cycle is masked.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_ena             block enable; 0 = no grants, config held, sticky capture continues
//   a_if, b_if        host A (SPI) and host B (I2C) access interfaces (slave side)
//   i_status_regs     core status, register k at [k*REG_WIDTH +: REG_WIDTH]
//   o_config_regs     config contents, register k at [k*REG_WIDTH +: REG_WIDTH]
//   o_irq             high while any sticky status bit is set
//
// Address map: 0..NUM_CFG-1 config (R/W), NUM_CFG..NUM_CFG+NUM_STATUS-1 status (RO),
// everything above is unmapped (err=1, read data 0).
module regbank_arb #(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter logic [NUM_STATUS*REG_WIDTH-1:0] STICKY_MASK = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_ena,
  regbank_arb_if.slave                    a_if,
  regbank_arb_if.slave                    b_if,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] i_status_regs,
  output logic [NUM_CFG*REG_WIDTH-1:0]    o_config_regs,
  output logic                            o_irq
);

  localparam int CFG_BITS  = NUM_CFG * REG_WIDTH;
  localparam int STAT_BITS = NUM_STATUS * REG_WIDTH;

  // Round-robin pointer: remembers which host was granted most recently.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  last_e                  r_last;
  logic                   r_a_ack;
  logic                   r_b_ack;
  logic                   r_a_err;
  logic                   r_b_err;
  logic [REG_WIDTH-1:0]   r_a_rdata;
  logic [REG_WIDTH-1:0]   r_b_rdata;
  logic [CFG_BITS-1:0]    r_cfg;
  logic [STAT_BITS-1:0]   r_sticky;
  logic                   r_irq;

  logic                   w_a_elig;
  logic                   w_b_elig;
  logic                   w_gnt_a;
  logic                   w_gnt_b;
  logic                   w_gnt;
  logic                   w_wr;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [REG_WIDTH-1:0]   w_wdata;
  logic [31:0]            w_addr32;
  logic [REG_WIDTH-1:0]   w_rdata;
  logic                   w_err;
  logic [CFG_BITS-1:0]    w_cfg_nxt;
  logic [STAT_BITS-1:0]   w_clr;
  logic [STAT_BITS-1:0]   w_sticky_nxt;
  logic [STAT_BITS-1:0]   w_status_view;

  // A host whose ack is high this cycle is not eligible: its req is either the
  // one just served (still held) or a fresh access that waits one cycle.
  assign w_a_elig = a_if.req & i_ena & ~r_a_ack;
  assign w_b_elig = b_if.req & i_ena & ~r_b_ack;

  // On contention the host not granted last wins.
  assign w_gnt_a = w_a_elig & (~w_b_elig | (r_last == LAST_B));
  assign w_gnt_b = w_b_elig & (~w_a_elig | (r_last == LAST_A));
  assign w_gnt   = w_gnt_a | w_gnt_b;

  // Only one host is granted per cycle, so a single decoder serves both.
  assign w_wr     = w_gnt_b ? b_if.wr    : a_if.wr;
  assign w_addr   = w_gnt_b ? b_if.addr  : a_if.addr;
  assign w_wdata  = w_gnt_b ? b_if.wdata : a_if.wdata;
  assign w_addr32 = 32'(w_addr);

  // Sticky register holds only masked bits, so OR-ing it with the live input
  // gives live bits for non-sticky positions and "latched or arriving now" for
  // sticky ones; a bit set on the clearing edge is therefore returned as 1.
  assign w_status_view = i_status_regs | r_sticky;

  always_comb begin
    w_cfg_nxt = r_cfg;
    w_clr     = '0;
    w_rdata   = '0;
    w_err     = 1'b1;

    for (int k = 0; k < NUM_CFG; k++) begin
      if (w_addr32 == 32'(k)) begin
        w_err = 1'b0;
        if (w_wr) begin
          if (w_gnt) begin
            w_cfg_nxt[k*REG_WIDTH +: REG_WIDTH] = w_wdata;
          end
        end else begin
          w_rdata = r_cfg[k*REG_WIDTH +: REG_WIDTH];
        end
      end
    end

    for (int k = 0; k < NUM_STATUS; k++) begin
      if (w_addr32 == 32'(NUM_CFG + k)) begin
        w_err = w_wr;
        if (!w_wr) begin
          w_rdata = w_status_view[k*REG_WIDTH +: REG_WIDTH];
          if (w_gnt) begin
            w_clr[k*REG_WIDTH +: REG_WIDTH] = '1;
          end
        end
      end
    end

    // Clear first, then capture: a same-edge event on a cleared bit survives.
    w_sticky_nxt = (r_sticky & ~w_clr) | (i_status_regs & STICKY_MASK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last    <= LAST_B;  // so host A wins the first contention
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_err   <= 1'b0;
      r_b_err   <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_cfg     <= '0;
      r_sticky  <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_cfg     <= w_cfg_nxt;
      r_sticky  <= w_sticky_nxt;
      r_irq     <= |w_sticky_nxt;
      r_a_ack   <= w_gnt_a;
      r_b_ack   <= w_gnt_b;
      r_a_err   <= w_gnt_a & w_err;
      r_b_err   <= w_gnt_b & w_err;
      r_a_rdata <= w_gnt_a ? w_rdata : '0;
      r_b_rdata <= w_gnt_b ? w_rdata : '0;
      if (w_gnt) begin
        r_last <= w_gnt_b ? LAST_B : LAST_A;
      end
    end
  end

  assign a_if.ack      = r_a_ack;
  assign a_if.rdata    = r_a_rdata;
  assign a_if.err      = r_a_err;
  assign b_if.ack      = r_b_ack;
  assign b_if.rdata    = r_b_rdata;
  assign b_if.err      = r_b_err;
  assign o_config_regs = r_cfg;
  assign o_irq         = r_irq;

endmodule
